// File: rtl/nic_pkg.sv
// nic_pkg: ring packet format shared by the NICs and the interrupt server,
// plus the server's register map, queued-request record and dispatch states.
package nic_pkg;

  // One ring slot. A slot is empty when both sid and did are zero.
  typedef struct packed {
    logic [5:0] did;    // destination node id (63 = broadcast)
    logic [5:0] sid;    // source node id
    logic [5:0] age;    // hops travelled since injection
    logic       firq;   // fast interrupt request
    logic [2:0] irq;    // interrupt level 1..7, 0 = none
    logic [7:0] cause;  // interrupt cause code
  } ipacket_t;

  localparam logic [5:0] IRQ_BROADCAST = 6'd63;

  // Word offsets (s_adr_i[5:2]) of the server registers.
  localparam logic [3:0] REG_TGT_FIRQ = 4'd0;  // 1..7 follow for irq levels
  localparam logic [3:0] REG_EOI      = 4'd8;
  localparam logic [3:0] REG_STATUS   = 4'd9;

  // Request as held in the server FIFO and dispatch register.
  typedef struct packed {
    logic [5:0] sid;
    logic       firq;
    logic [2:0] irq;
    logic [7:0] cause;
  } irq_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } disp_state_e;

endpackage

// File: rtl/rf68000_irq_fifo.sv
// rf68000_irq_fifo: synchronous request FIFO for the interrupt server.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   push_i / wdata_i    write request (ignored while full)
//   pop_i / rdata_o     read request (ignored while empty); rdata_o shows the head
//   full_o, empty_o     occupancy flags
//   count_o             occupancy, one bit wider than the pointers
//   match_sid_i/match_o match_o is set when any valid entry holds match_sid_i
module rf68000_irq_fifo
  import nic_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  irq_req_t   wdata_i,
  input  logic       pop_i,
  output irq_req_t   rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [AW:0] count_o,
  input  logic [5:0] match_sid_i,
  output logic       match_o
);

  irq_req_t         mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] hit;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // An entry is live when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [AW-1:0] offs;
      assign offs    = AW'(gi) - rd_ptr_q;
      assign hit[gi] = ({1'b0, offs} < count_q) && (mem_q[gi].sid == match_sid_i);
    end
  endgenerate

  assign match_o = |hit;

endmodule

// File: rtl/rf68000_irq_server.sv
// rf68000_irq_server: interrupt server node on the rf68000 ring.
// Consumes ipackets addressed to `id`, drops duplicates of sources already
// queued or in service, queues the rest and re-emits them one at a time to a
// per-level target core (0 = broadcast). A source stays in service until EOI.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id                      this node's ring id
//   ipacket_i / ipacket_o   ring in / registered ring out
//   s_*                     register slave (targets, EOI, status)
//   pending_o               FIFO occupancy
//   ovf_o                   sticky: a request was refused on a full FIFO
module rf68000_irq_server
  import nic_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter logic [5:0] MAX_AGE = 6'd62
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  id,
  input  ipacket_t    ipacket_i,
  output ipacket_t    ipacket_o,
  input  logic        s_cs_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [5:0]  s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [4:0]  pending_o,
  output logic        ovf_o
);

  localparam int AW = $clog2(DEPTH);

  ipacket_t    ipacket_q, ipacket_d;
  disp_state_e state_q, state_d;
  irq_req_t    disp_q, disp_d;
  logic [63:0] in_svc_q, in_svc_d, in_svc_eff;
  logic [5:0]  target_q [8];
  logic [5:0]  target_d [8];
  logic        ovf_q, ovf_d, ack1_q, ack1_d;
  logic [31:0] s_dat_q, s_dat_d;

  irq_req_t    fifo_wdata, fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_match;
  logic [AW:0] fifo_count;

  logic       occupied, hit, is_null, dup, do_push, refuse, consume, purge;
  logic       slot_free, wr_stb, eoi_wr, do_pop, do_disp;
  logic [5:0] disp_tgt;
  logic       unused_ok;

  assign unused_ok = ^{s_dat_i[31:6], s_adr_i[1:0]};

  assign occupied = (ipacket_i.sid | ipacket_i.did) != 6'd0;
  assign hit      = (ipacket_i.did == id);
  assign is_null  = !ipacket_i.firq && (ipacket_i.irq == 3'd0);

  // A bus write lands only on the first cycle of its strobe.
  assign wr_stb = s_cs_i & s_cyc_i & s_stb_i & s_we_i & ~ack1_q;
  assign eoi_wr = wr_stb && (s_adr_i[5:2] == REG_EOI);

  // EOI is applied before the duplicate check so a same-cycle re-request passes.
  always_comb begin
    in_svc_eff = in_svc_q;
    if (eoi_wr) in_svc_eff[s_dat_i[5:0]] = 1'b0;
  end

  assign dup = in_svc_eff[ipacket_i.sid] | fifo_match |
               ((state_q == ST_WAIT) && (disp_q.sid == ipacket_i.sid));

  assign do_push   = hit && !is_null && !dup && !fifo_full;
  assign refuse    = hit && !is_null && !dup && fifo_full;
  assign consume   = hit && !refuse;
  assign purge     = occupied && !hit && (ipacket_i.age >= MAX_AGE);
  assign slot_free = !occupied || consume || purge;
  assign do_pop    = (state_q == ST_IDLE) && !fifo_empty;
  assign do_disp   = (state_q == ST_WAIT) && slot_free;
  assign disp_tgt  = target_q[disp_q.firq ? 3'd0 : disp_q.irq];

  assign fifo_wdata = '{sid: ipacket_i.sid, firq: ipacket_i.firq,
                        irq: ipacket_i.irq, cause: ipacket_i.cause};

  rf68000_irq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (do_push),
    .wdata_i     (fifo_wdata),
    .pop_i       (do_pop),
    .rdata_o     (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .match_sid_i (ipacket_i.sid),
    .match_o     (fifo_match)
  );

  assign pending_o = 5'(fifo_count);

  always_comb begin
    state_d   = state_q;
    disp_d    = disp_q;
    in_svc_d  = in_svc_eff;
    ovf_d     = ovf_q;
    target_d  = target_q;
    ack1_d    = s_cs_i & s_cyc_i & s_stb_i;
    s_dat_d   = s_dat_q;

    // Ring pass-through, then local consume/purge, then our own dispatch.
    ipacket_d = ipacket_i;
    if (occupied) ipacket_d.age = ipacket_i.age + 6'd1;
    if (consume || purge) ipacket_d = '0;

    if (do_pop) begin
      disp_d  = fifo_rdata;
      state_d = ST_WAIT;
    end
    if (do_disp) begin
      ipacket_d.did   = (disp_tgt == 6'd0) ? IRQ_BROADCAST : disp_tgt;
      ipacket_d.sid   = id;
      ipacket_d.age   = 6'd0;
      ipacket_d.firq  = disp_q.firq;
      ipacket_d.irq   = disp_q.irq;
      ipacket_d.cause = disp_q.cause;
      in_svc_d[disp_q.sid] = 1'b1;
      state_d = ST_IDLE;
    end

    if (wr_stb && !s_adr_i[5]) target_d[s_adr_i[4:2]] = s_dat_i[5:0];
    if (wr_stb && (s_adr_i[5:2] == REG_STATUS)) ovf_d = 1'b0;
    if (refuse) ovf_d = 1'b1;

    if (ack1_d) begin
      if (!s_adr_i[5])                        s_dat_d = {26'd0, target_q[s_adr_i[4:2]]};
      else if (s_adr_i[5:2] == REG_STATUS)    s_dat_d = {25'd0, ovf_q, pending_o, 1'b0};
      else                                    s_dat_d = 32'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ipacket_q <= '0;
      state_q   <= ST_IDLE;
      disp_q    <= '0;
      in_svc_q  <= '0;
      ovf_q     <= 1'b0;
      ack1_q    <= 1'b0;
      s_dat_q   <= '0;
      for (int i = 0; i < 8; i++) target_q[i] <= '0;
    end else begin
      ipacket_q <= ipacket_d;
      state_q   <= state_d;
      disp_q    <= disp_d;
      in_svc_q  <= in_svc_d;
      ovf_q     <= ovf_d;
      ack1_q    <= ack1_d;
      s_dat_q   <= s_dat_d;
      target_q  <= target_d;
    end
  end

  assign ipacket_o = ipacket_q;
  assign s_dat_o   = s_dat_q;
  assign s_ack_o   = ack1_q & s_cyc_i & s_stb_i;
  assign ovf_o     = ovf_q;

endmodule
